// File: rtl/instr_mem_sync_if.sv
// Fetch-side and program-load bus of the synchronous instruction memory.
// The master is the fetch stage / loader; the slave is the memory itself.
interface instr_mem_sync_if #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int IDX_W = $clog2(DEPTH);

    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  stall;
    logic                  flush;
    logic [31:0]           instruction;
    logic                  instr_valid;
    logic                  addr_fault;
    logic                  fetch_ready;
    logic                  prog_we;
    logic [IDX_W-1:0]      prog_addr;
    logic [31:0]           prog_data;

    modport master (
        output fetch_en, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
        input  instruction, instr_valid, addr_fault, fetch_ready
    );

    modport slave (
        input  fetch_en, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
        output instruction, instr_valid, addr_fault, fetch_ready
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with a NOP-fill init sequencer, runtime
// program load, registered one-cycle fetch, stall/flush and fault reporting.
module instr_mem_sync #(
    parameter int          DEPTH      = 256,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_WORD   = 32'hE1A00000
) (
    input logic             clock,
    input logic             reset_n,
    instr_mem_sync_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH);
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] init_count;

    logic [31:0]      mem [DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic [IDX_W-1:0] fetch_index;
    logic             fetch_fault;
    logic             fetch_accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            init_count <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_count <= init_count + 1'b1;
            end
        end
    end

    // The single memory write port is shared by the NOP filler and the loader.
    always_comb begin
        state_next      = state;
        bus.fetch_ready = 1'b0;
        mem_we          = 1'b0;
        mem_waddr       = init_count;
        mem_wdata       = NOP_WORD;
        case (state)
            INIT: begin
                mem_we = 1'b1;
                if (init_count == LAST_INDEX) begin
                    state_next = READY;
                end
            end
            READY: begin
                bus.fetch_ready = 1'b1;
                mem_we          = bus.prog_we;
                mem_waddr       = bus.prog_addr;
                mem_wdata       = bus.prog_data;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Range check is done one bit wider so 4*DEPTH never wraps.
    always_comb begin
        fetch_index  = bus.fetch_addr[IDX_W+1:2];
        fetch_fault  = (bus.fetch_addr[1:0] != 2'b00) ||
                       ({1'b0, bus.fetch_addr} >= ADDR_LIMIT);
        fetch_accept = (state == READY) && bus.fetch_en;
    end

    // Reading mem here before the write port's update gives read-before-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.instruction <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.addr_fault  <= 1'b0;
        end else if (bus.flush) begin
            bus.instruction <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.addr_fault  <= 1'b0;
        end else if (!bus.stall) begin
            if (fetch_accept) begin
                bus.instr_valid <= 1'b1;
                bus.addr_fault  <= fetch_fault;
                bus.instruction <= fetch_fault ? NOP_WORD : mem[fetch_index];
            end else begin
                bus.instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync (DEPTH=16): directed plan followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_instr_mem_sync;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'hE1A00000;

    logic clock;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    int          init_edges;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_fault;

    instr_mem_sync_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) bus ();

    instr_mem_sync #(
        .DEPTH(DEPTH),
        .ADDR_WIDTH(32),
        .NOP_WORD(NOP)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        init_edges = 0;
        exp_instr  = NOP;
        exp_valid  = 1'b0;
        exp_fault  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic exp_ready;
        exp_ready = (init_edges >= DEPTH);
        checks++;
        assert (bus.instruction === exp_instr) else begin
            failures++;
            $error("[TB] FAIL %s instruction actual=%h required=%h", tag, bus.instruction, exp_instr);
        end
        checks++;
        assert (bus.instr_valid === exp_valid) else begin
            failures++;
            $error("[TB] FAIL %s instr_valid actual=%b required=%b", tag, bus.instr_valid, exp_valid);
        end
        checks++;
        assert (bus.addr_fault === exp_fault) else begin
            failures++;
            $error("[TB] FAIL %s addr_fault actual=%b required=%b", tag, bus.addr_fault, exp_fault);
        end
        checks++;
        assert (bus.fetch_ready === exp_ready) else begin
            failures++;
            $error("[TB] FAIL %s fetch_ready actual=%b required=%b", tag, bus.fetch_ready, exp_ready);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic fe, input logic [31:0] addr,
                                 input logic st, input logic fl, input logic we,
                                 input logic [3:0] pa, input logic [31:0] pd,
                                 input string tag);
        logic ready_before;
        logic bad;
        bus.fetch_en   = fe;
        bus.fetch_addr = addr;
        bus.stall      = st;
        bus.flush      = fl;
        bus.prog_we    = we;
        bus.prog_addr  = pa;
        bus.prog_data  = pd;
        @(posedge clock);
        ready_before = (init_edges >= DEPTH);
        if (fl) begin
            exp_valid = 1'b0;
            exp_instr = NOP;
            exp_fault = 1'b0;
        end else if (!st) begin
            if (ready_before && fe) begin
                bad       = (addr % 4 != 0) || (addr >= 4 * DEPTH);
                exp_valid = 1'b1;
                exp_fault = bad;
                exp_instr = bad ? NOP : model_mem[addr / 4];
            end else begin
                exp_valid = 1'b0;
            end
        end
        if (ready_before && we) model_mem[pa] = pd;
        if (init_edges < DEPTH) init_edges++;
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, tag);
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, tag);
    endtask

    task automatic load(input logic [3:0] pa, input logic [31:0] pd, input string tag);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pa, pd, tag);
    endtask

    // Runs the NOP-fill pass, pulsing prog_we on the way to show it is ignored.
    task automatic runInit(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, i[0], 4'(i), 32'hDEAD0000 | i, tag);
        end
    endtask

    initial begin
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [3:0]  ridx;
        logic        rfe;
        logic        rst;
        logic        rfl;
        logic        rwe;

        reset_n        = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_values");
        @(negedge clock);
        reset_n = 1'b1;
        $display("[TB] reset released, init pass");

        runInit("init");
        fetch(32'h8, "first_fetch_nop");

        load(4'd0, 32'hE3A00014, "load0");
        load(4'd1, 32'hE3A01A01, "load1");
        load(4'd2, 32'hE0923002, "load2");
        fetch(32'h0, "b2b_0");
        fetch(32'h4, "b2b_4");
        fetch(32'h8, "b2b_8");
        idle("b2b_drain");

        fetch(32'h6, "misaligned");
        fetch(32'h40, "out_of_range");
        fetch(32'h3C, "last_word");
        fetch(32'hFFFF_FFFC, "far_out_of_range");

        fetch(32'h4, "pre_stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, "stall_hold");
        end
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, "stall_flush");
        idle("post_flush");

        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 4'd5, 32'h12345678, "rbw_old");
        fetch(32'h14, "rbw_new");

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    raddr = 32'($urandom_range(0, DEPTH - 1)) * 4;
                2:       raddr = 32'($urandom_range(0, 'h7F));
                default: raddr = $urandom;
            endcase
            rdata = $urandom;
            ridx  = 4'($urandom_range(0, DEPTH - 1));
            rfe   = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 4) == 0);
            rfl   = ($urandom_range(0, 7) == 0);
            rwe   = ($urandom_range(0, 2) == 0);
            applyStimulus(rfe, raddr, rst, rfl, rwe, ridx, rdata, "random");
        end

        fetch(32'h0, "pre_reset_fetch");
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 32'h4;
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 4'd0;
        bus.prog_data  = 32'hCAFEF00D;
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        runInit("reinit");
        fetch(32'h0, "reinit_mem0");
        fetch(32'h8, "reinit_mem2");
        idle("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
